// File: rtl/biquad_coeff_pkg.sv
// Shared register map, field offsets and counter types for the coefficient controller.
package biquad_coeff_pkg;

    // Register index = wb_adr_i[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_FIR    = 3'd1;
    localparam logic [2:0] REG_IIR    = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_POLE0  = 3'd4;

    // CTRL bit positions
    localparam int CTRL_UPDATE = 0;
    localparam int CTRL_FORCE  = 1;
    localparam int CTRL_CLRERR = 2;

    // STATUS field offsets
    localparam int STAT_FIR_LSB     = 0;
    localparam int STAT_POLE_LSB    = 8;
    localparam int STAT_IIR_LSB     = 16;
    localparam int STAT_ERR_PARTIAL = 24;
    localparam int STAT_ERR_OVF     = 25;

    // Counters must hold the largest full-set size (16 pole-FIR words)
    localparam int CNT_W = 5;

    typedef struct packed {
        logic [CNT_W-1:0] fir;
        logic [CNT_W-1:0] pole;
        logic [CNT_W-1:0] iir;
    } chan_cnt_t;

    // Increment that sticks at the full-set size
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W-1:0] lim);
        return (cnt == lim) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/biquad_coeff_chan.sv
// Per-channel write counters, error flags and the "complete or untouched" update check.
module biquad_coeff_chan
    import biquad_coeff_pkg::*;
#(
    parameter int FIR_NCOEF  = 8,
    parameter int POLE_NCOEF = 16,
    parameter int IIR_NCOEF  = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr_fir,
    input  logic      wr_pole,
    input  logic      wr_iir,
    input  logic      chk_req,
    input  logic      force_req,
    input  logic      clr_err,
    output chan_cnt_t cnt,
    output logic      err_partial,
    output logic      err_ovf,
    output logic      grp_ok,
    output logic      update
);

    localparam logic [CNT_W-1:0] FIR_MAX  = CNT_W'(FIR_NCOEF);
    localparam logic [CNT_W-1:0] POLE_MAX = CNT_W'(POLE_NCOEF);
    localparam logic [CNT_W-1:0] IIR_MAX  = CNT_W'(IIR_NCOEF);

    logic fir_full, pole_full, iir_full;
    logic do_update, chk_fail, ovf;

    // Group completeness, update decision and overflow detection
    always_comb begin
        fir_full  = (cnt.fir  == FIR_MAX);
        pole_full = (cnt.pole == POLE_MAX);
        iir_full  = (cnt.iir  == IIR_MAX);
        grp_ok    = ((cnt.fir  == '0) || fir_full)  &&
                    ((cnt.pole == '0) || pole_full) &&
                    ((cnt.iir  == '0) || iir_full);
        // FORCE bypasses the completeness check entirely
        do_update = force_req | (chk_req & grp_ok);
        chk_fail  = chk_req & ~force_req & ~grp_ok;
        ovf       = (wr_fir & fir_full) | (wr_pole & pole_full) | (wr_iir & iir_full);
    end

    // Saturating write counters, cleared whenever the channel goes live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (do_update) begin
            cnt <= '0;
        end else begin
            if (wr_fir)  cnt.fir  <= sat_inc(cnt.fir,  FIR_MAX);
            if (wr_pole) cnt.pole <= sat_inc(cnt.pole, POLE_MAX);
            if (wr_iir)  cnt.iir  <= sat_inc(cnt.iir,  IIR_MAX);
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes precedence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_partial <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            if (chk_fail)     err_partial <= 1'b1;
            else if (clr_err) err_partial <= 1'b0;
            if (ovf)          err_ovf     <= 1'b1;
            else if (clr_err) err_ovf     <= 1'b0;
        end
    end

    // One-cycle update strobe toward the filter core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) update <= 1'b0;
        else        update <= do_update;
    end

endmodule

// File: rtl/biquad_coeff_ctrl.sv
// WISHBONE-to-coefficient-bus controller: decode, readback mirror and gated channel updates.
module biquad_coeff_ctrl
    import biquad_coeff_pkg::*;
#(
    parameter int NCHAN      = 4,
    parameter int COEFF_BITS = 18,
    parameter int FIR_NCOEF  = 8,
    parameter int POLE_NCOEF = 16,
    parameter int IIR_NCOEF  = 4,
    parameter int ADR_BITS   = 5 + $clog2(NCHAN)
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADR_BITS-1:0]   wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    input  logic                  global_update_i,
    output logic [COEFF_BITS-1:0] coeff_dat_o,
    output logic [NCHAN-1:0]      coeff_fir_wr_o,
    output logic [NCHAN-1:0]      coeff_polefir_wr_o,
    output logic [NCHAN-1:0]      coeff_iir_wr_o,
    output logic [1:0]            coeff_polefir_adr_o,
    output logic [NCHAN-1:0]      coeff_update_o
);

    localparam int CH_BITS = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic                  accept, wr_acc, coef_wr, ctrl_wr, rd_acc, bus_fail;
    logic                  is_fir, is_iir, is_pole;
    logic                  defer_q, defer_d, glob_eval;
    logic [2:0]            reg_idx;
    logic [CH_BITS-1:0]    ch;
    logic [NCHAN-1:0]      chan_hit, wr_fir, wr_pole, wr_iir, chk_req, force_req, clr_err;
    logic [NCHAN-1:0]      grp_ok, err_partial, err_ovf;
    chan_cnt_t             cnt [NCHAN];
    logic [31:0]           status, rdata;
    logic                  unused_bits;
    logic [COEFF_BITS-1:0] mem [NCHAN*8];

    assign wb_rty_o    = 1'b0;
    assign unused_bits = ^{wb_dat_i, wb_sel_i};

    if (NCHAN > 1) begin : g_ch
        assign ch = wb_adr_i[ADR_BITS-1:5];
    end else begin : g_ch1
        assign ch = 1'b0;
    end

    // Access decode, global-update deferral and per-channel request fan-out
    always_comb begin
        accept  = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
        reg_idx = wb_adr_i[4:2];
        is_fir  = (reg_idx == REG_FIR);
        is_iir  = (reg_idx == REG_IIR);
        is_pole = (reg_idx >= REG_POLE0);
        wr_acc  = accept & wb_we_i & wb_sel_i[0];
        coef_wr = wr_acc & (is_fir | is_iir | is_pole);
        ctrl_wr = wr_acc & (reg_idx == REG_CTRL);
        rd_acc  = accept & ~wb_we_i;
        // Global update must not share a cycle with a strobe: push it one cycle
        // later so it sees the counts including this write; repeats merge
        glob_eval = (global_update_i | defer_q) & ~coef_wr;
        defer_d   = (global_update_i | defer_q) &  coef_wr;
        bus_fail  = ctrl_wr & wb_dat_i[CTRL_UPDATE] & ~wb_dat_i[CTRL_FORCE] & ~grp_ok[ch];
        for (int i = 0; i < NCHAN; i++) begin
            chan_hit[i]  = (ch == CH_BITS'(i));
            wr_fir[i]    = coef_wr & chan_hit[i] & is_fir;
            wr_pole[i]   = coef_wr & chan_hit[i] & is_pole;
            wr_iir[i]    = coef_wr & chan_hit[i] & is_iir;
            chk_req[i]   = glob_eval | (ctrl_wr & chan_hit[i] & wb_dat_i[CTRL_UPDATE]);
            force_req[i] = ctrl_wr & chan_hit[i] & wb_dat_i[CTRL_FORCE];
            clr_err[i]   = ctrl_wr & chan_hit[i] & wb_dat_i[CTRL_CLRERR];
        end
    end

    // Read mux: CTRL reads 0, STATUS from the channel block, rest from the mirror
    always_comb begin
        status = '0;
        status[STAT_FIR_LSB  +: CNT_W]  = cnt[ch].fir;
        status[STAT_POLE_LSB +: CNT_W]  = cnt[ch].pole;
        status[STAT_IIR_LSB  +: CNT_W]  = cnt[ch].iir;
        status[STAT_ERR_PARTIAL]        = err_partial[ch];
        status[STAT_ERR_OVF]            = err_ovf[ch];
        case (reg_idx)
            REG_CTRL:   rdata = '0;
            REG_STATUS: rdata = status;
            default:    rdata = 32'(mem[{ch, reg_idx}]);
        endcase
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        biquad_coeff_chan #(
            .FIR_NCOEF  (FIR_NCOEF),
            .POLE_NCOEF (POLE_NCOEF),
            .IIR_NCOEF  (IIR_NCOEF)
        ) u_chan (
            .clk         (wb_clk_i),
            .rst_n       (wb_rst_ni),
            .wr_fir      (wr_fir[i]),
            .wr_pole     (wr_pole[i]),
            .wr_iir      (wr_iir[i]),
            .chk_req     (chk_req[i]),
            .force_req   (force_req[i]),
            .clr_err     (clr_err[i]),
            .cnt         (cnt[i]),
            .err_partial (err_partial[i]),
            .err_ovf     (err_ovf[i]),
            .grp_ok      (grp_ok[i]),
            .update      (coeff_update_o[i])
        );
    end

    // Registered bus termination, read data and coefficient strobes
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o            <= 1'b0;
            wb_err_o            <= 1'b0;
            wb_dat_o            <= '0;
            coeff_dat_o         <= '0;
            coeff_polefir_adr_o <= '0;
            coeff_fir_wr_o      <= '0;
            coeff_polefir_wr_o  <= '0;
            coeff_iir_wr_o      <= '0;
            defer_q             <= 1'b0;
        end else begin
            wb_ack_o           <= accept & ~bus_fail;
            wb_err_o           <= bus_fail;
            wb_dat_o           <= rd_acc ? rdata : '0;
            coeff_fir_wr_o     <= wr_fir;
            coeff_polefir_wr_o <= wr_pole;
            coeff_iir_wr_o     <= wr_iir;
            defer_q            <= defer_d;
            if (coef_wr)           coeff_dat_o         <= wb_dat_i[COEFF_BITS-1:0];
            if (coef_wr & is_pole) coeff_polefir_adr_o <= wb_adr_i[3:2];
        end
    end

    // Readback mirror; contents are deliberately left unreset
    always_ff @(posedge wb_clk_i) begin
        if (coef_wr) mem[{ch, reg_idx}] <= wb_dat_i[COEFF_BITS-1:0];
    end

endmodule

// File: tb/tb_biquad_coeff_ctrl.sv
// Directed scoreboard bench for biquad_coeff_ctrl (NCHAN=4 defaults).
module tb_biquad_coeff_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, glob = 1'b0;
    logic [6:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_o;
    logic        ack, err, rty;
    logic [17:0] cdat;
    logic [3:0]  fir_wr, pole_wr, iir_wr, upd;
    logic [1:0]  padr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [17:0] ctl;   // {ack, err, fir, pole, iir, upd}
        logic [17:0] cdat;
        logic [1:0]  padr;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    biquad_coeff_ctrl dut (
        .wb_clk_i            (clk),
        .wb_rst_ni           (rst_n),
        .wb_cyc_i            (cyc),
        .wb_stb_i            (stb),
        .wb_we_i             (we),
        .wb_adr_i            (adr),
        .wb_dat_i            (dat_i),
        .wb_sel_i            (sel),
        .wb_dat_o            (dat_o),
        .wb_ack_o            (ack),
        .wb_err_o            (err),
        .wb_rty_o            (rty),
        .global_update_i     (glob),
        .coeff_dat_o         (cdat),
        .coeff_fir_wr_o      (fir_wr),
        .coeff_polefir_wr_o  (pole_wr),
        .coeff_iir_wr_o      (iir_wr),
        .coeff_polefir_adr_o (padr),
        .coeff_update_o      (upd)
    );

    task automatic expect_ev(input string name, input logic a, input logic e,
                             input logic [3:0] f, input logic [3:0] p, input logic [3:0] i,
                             input logic [3:0] u, input logic [17:0] cd, input logic [1:0] pa,
                             input logic chk, input logic [31:0] rd);
        exp_t x;
        x.name = name; x.ctl = {a, e, f, p, i, u}; x.cdat = cd; x.padr = pa;
        x.chk_rd = chk; x.rd = rd;
        sb.push_back(x);
    endtask

    task automatic bus(input logic w, input int ch, input int idx, input logic [31:0] d,
                       input logic [3:0] s);
        int n;
        n = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = 7'((ch << 5) | (idx << 2)); dat_i = d; sel = s;
        do begin
            @(posedge clk); #1; n++;
        end while (!(ack | err) && n < 20);
        if (!(ack | err)) begin
            total++; bad++;
            $display("FAIL bus_timeout ch=%0d idx=%0d: got no ack/err in 20 cycles, need one", ch, idx);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Coefficient write: strobe group follows from the register map
    task automatic coef(input int ch, input int idx, input logic [31:0] d);
        logic [3:0] oh;
        oh = 4'(1 << ch);
        expect_ev($sformatf("coef_ch%0d_r%0d", ch, idx), 1'b1, 1'b0,
                  (idx == 1) ? oh : 4'h0, (idx >= 4) ? oh : 4'h0, (idx == 2) ? oh : 4'h0,
                  4'h0, d[17:0], 2'(idx & 3), 1'b0, 32'h0);
        bus(1'b1, ch, idx, d, 4'hF);
    endtask

    task automatic ctrl(input int ch, input logic [31:0] v, input logic e, input logic [3:0] u);
        expect_ev($sformatf("ctrl_ch%0d_%0h", ch, v), ~e, e, 4'h0, 4'h0, 4'h0, u,
                  18'h0, 2'h0, 1'b0, 32'h0);
        bus(1'b1, ch, 0, v, 4'hF);
    endtask

    task automatic rd(input int ch, input int idx, input logic [31:0] v);
        expect_ev($sformatf("read_ch%0d_r%0d", ch, idx), 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
                  18'h0, 2'h0, 1'b1, v);
        bus(1'b0, ch, idx, 32'h0, 4'hF);
    endtask

    task automatic wr_noeffect(input int ch, input int idx, input logic [31:0] d,
                               input logic [3:0] s);
        expect_ev($sformatf("noeff_ch%0d_r%0d", ch, idx), 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
                  18'h0, 2'h0, 1'b0, 32'h0);
        bus(1'b1, ch, idx, d, s);
    endtask

    task automatic check_zero(input string name);
        logic [72:0] v;
        v = {ack, err, rty, dat_o, cdat, fir_wr, pole_wr, iir_wr, padr, upd};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL %s: outputs got %h, need all zero", name, v);
        end
    endtask

    // Monitor: any bus termination, strobe or update pops one expected event
    always @(negedge clk) begin
        logic [17:0] act;
        exp_t        e;
        act = {ack, err, fir_wr, pole_wr, iir_wr, upd};
        if (act != '0) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_output: got ctl=%h, need no activity", act);
            end else begin
                e = sb.pop_front();
                total++;
                if (act !== e.ctl) begin
                    bad++;
                    $display("FAIL %s ctl: got %h, need %h", e.name, act, e.ctl);
                end
                if (|{fir_wr, pole_wr, iir_wr}) begin
                    total++;
                    if (cdat !== e.cdat) begin
                        bad++;
                        $display("FAIL %s coeff_dat: got %h, need %h", e.name, cdat, e.cdat);
                    end
                end
                if (|pole_wr) begin
                    total++;
                    if (padr !== e.padr) begin
                        bad++;
                        $display("FAIL %s polefir_adr: got %0d, need %0d", e.name, padr, e.padr);
                    end
                end
                if (e.chk_rd) begin
                    total++;
                    if (dat_o !== e.rd) begin
                        bad++;
                        $display("FAIL %s rdata: got %h, need %h", e.name, dat_o, e.rd);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        rst_n = 1'b1;

        // Full FIR set on ch2 goes live with a checked update
        for (int i = 1; i <= 8; i++) coef(2, 1, 32'(i));
        ctrl(2, 32'h1, 1'b0, 4'b0100);
        rd(2, 3, 32'h0);

        // Partial IIR set on ch0 is refused, then forced
        for (int i = 0; i < 3; i++) coef(0, 2, 32'h11 + 32'(i));
        ctrl(0, 32'h1, 1'b1, 4'b0000);
        rd(0, 3, 32'h0103_0000);
        ctrl(0, 32'h2, 1'b0, 4'b0001);
        rd(0, 3, 32'h0100_0000);
        ctrl(0, 32'h4, 1'b0, 4'b0000);
        rd(0, 3, 32'h0);

        // Pole-FIR sub-address and mirror readback
        coef(1, 6, 32'h2ABCD);
        rd(1, 6, 32'h2ABCD);
        rd(2, 1, 32'h8);
        ctrl(1, 32'h2, 1'b0, 4'b0010);

        // Global update: ch1 complete, ch3 partial, ch0/ch2 untouched
        for (int i = 0; i < 4; i++) coef(1, 2, 32'h21 + 32'(i));
        for (int i = 0; i < 5; i++) coef(3, 1, 32'h31 + 32'(i));
        expect_ev("global_upd", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0111, 18'h0, 2'h0, 1'b0, 32'h0);
        @(posedge clk); #1; glob = 1'b1;
        @(posedge clk); #1; glob = 1'b0;
        repeat (2) @(posedge clk);
        rd(3, 3, 32'h0100_0005);
        ctrl(3, 32'h2, 1'b0, 4'b1000);
        ctrl(3, 32'h4, 1'b0, 4'b0000);
        rd(3, 3, 32'h0);

        // Global update colliding with the 8th FIR write on ch0 is deferred
        for (int i = 0; i < 7; i++) coef(0, 1, 32'h41 + 32'(i));
        expect_ev("defer_wr", 1'b1, 1'b0, 4'b0001, 4'h0, 4'h0, 4'h0, 18'h3FFFF, 2'h0, 1'b0, 32'h0);
        expect_ev("defer_upd", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b1111, 18'h0, 2'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h04; dat_i = 32'h3FFFF; sel = 4'hF; glob = 1'b1;
        @(posedge clk); #1;
        glob = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (3) @(posedge clk);
        rd(0, 3, 32'h0);

        // Overflow on ch2 IIR, then FORCE wins over a failing UPDATE
        for (int i = 0; i < 5; i++) coef(2, 2, 32'h51 + 32'(i));
        coef(2, 1, 32'h77);
        rd(2, 3, 32'h0204_0001);
        ctrl(2, 32'h3, 1'b0, 4'b0100);
        rd(2, 3, 32'h0200_0000);
        ctrl(2, 32'h4, 1'b0, 4'b0000);
        rd(2, 3, 32'h0);

        // Writes without sel[0] and to STATUS have no effect; CTRL reads 0
        wr_noeffect(2, 1, 32'h12345, 4'b1110);
        rd(2, 1, 32'h77);
        rd(2, 3, 32'h0);
        wr_noeffect(1, 3, 32'hFFFF_FFFF, 4'hF);
        rd(1, 3, 32'h0);
        rd(1, 0, 32'h0);

        // Cycle dropped before acceptance leaves no trace
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h24; dat_i = 32'h5; sel = 4'hF;
        #2; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (3) @(posedge clk);
        rd(1, 3, 32'h0);

        // Reset in the acceptance cycle
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h04; dat_i = 32'h99; sel = 4'hF;
        #2; rst_n = 1'b0;
        #1; check_zero("rst_async_accept");
        @(posedge clk); #1;
        check_zero("rst_no_ack");
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;

        // Reset in the ack cycle kills strobe, ack and the deferred update
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h04; dat_i = 32'h9A; sel = 4'hF; glob = 1'b1;
        @(posedge clk); #1;
        glob = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        total++;
        if ({ack, fir_wr} !== 5'b1_0001) begin
            bad++;
            $display("FAIL pre_rst_ack: got ack/fir=%b, need 10001", {ack, fir_wr});
        end
        rst_n = 1'b0;
        #1; check_zero("rst_async_ack");
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (4) @(posedge clk);
        rd(0, 3, 32'h0);

        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending events, need 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
